// File: rtl/pic_debug_ctrl.sv
// Run-control sequencer for the PIC16C5x core: halt, run, N-step and one PC breakpoint.
// Optional retired-instruction counter enabled by defining DBG_INST_COUNT_EN.
module pic_debug_ctrl #(
  parameter int PC_WIDTH     = 9,
  parameter int STEP_W       = 8,
  parameter int START_HALTED = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [PC_WIDTH-1:0] cmd_arg,
  input  logic                halt_req,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                inst_done,
  output logic                core_en,
  output logic                halted,
  output logic                bp_hit,
  output logic                step_done,
  output logic [15:0]         inst_count
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam state_e     RESET_STATE = (START_HALTED != 0) ? ST_HALT : ST_RUN;
  localparam logic [2:0] OP_HALT     = 3'd1;
  localparam logic [2:0] OP_RUN      = 3'd2;
  localparam logic [2:0] OP_STEP     = 3'd3;
  localparam logic [2:0] OP_SET_BP   = 3'd4;
  localparam logic [2:0] OP_CLR_BP   = 3'd5;

  state_e                state_q, state_d;
  logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
  logic [PC_WIDTH-1:0]   bp_addr_q, bp_addr_d;
  logic                  bp_en_q, bp_en_d;
  logic                  bp_hit_q, bp_hit_d;
  logic                  step_done_q, step_done_d;

  logic                  cmd_fire_s;
  logic                  counted_s;
  logic                  bp_match_s;
  logic                  step_last_s;
  logic                  resume_s;
  logic [STEP_W-1:0]     step_arg_s;
  logic [STEP_W-1:0]     step_load_s;

  assign core_en     = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign halted      = (state_q == ST_HALT);
  assign cmd_ready   = !halt_req && (state_q != ST_STEP);
  assign bp_hit      = bp_hit_q;
  assign step_done   = step_done_q;

  assign cmd_fire_s  = cmd_valid && cmd_ready;
  assign counted_s   = inst_done && core_en;
  assign bp_match_s  = counted_s && bp_en_q && (pc_in == bp_addr_q);
  assign step_last_s = counted_s && (state_q == ST_STEP) && (step_cnt_q == STEP_W'(1));
  assign resume_s    = cmd_fire_s && (state_q == ST_HALT) &&
                       ((cmd_op == OP_RUN) || (cmd_op == OP_STEP));

  // Step count argument: cast truncates or zero-extends cmd_arg; zero means one step
  always_comb begin
    step_arg_s  = STEP_W'(cmd_arg);
    step_load_s = step_arg_s;
    if (step_arg_s == '0) begin
      step_load_s = STEP_W'(1);
    end else begin
      step_load_s = step_arg_s;
    end
  end

  // Next-state logic: commands, then retirement events, then halt_req on top
  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    bp_addr_d   = bp_addr_q;
    bp_en_d     = bp_en_q;
    bp_hit_d    = bp_match_s;
    step_done_d = step_last_s;

    case (state_q)
      ST_HALT: begin
        if (cmd_fire_s && (cmd_op == OP_RUN)) begin
          state_d = ST_RUN;
        end else if (cmd_fire_s && (cmd_op == OP_STEP)) begin
          state_d    = ST_STEP;
          step_cnt_d = step_load_s;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        if (cmd_fire_s && (cmd_op == OP_HALT)) begin
          state_d = ST_HALT;
        end else if (cmd_fire_s && (cmd_op == OP_STEP)) begin
          state_d    = ST_STEP;
          step_cnt_d = step_load_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        if (counted_s) begin
          step_cnt_d = step_cnt_q - STEP_W'(1);
        end else begin
          step_cnt_d = step_cnt_q;
        end
      end
      default: begin
        state_d    = RESET_STATE;
        step_cnt_d = '0;
      end
    endcase

    if (cmd_fire_s && (cmd_op == OP_SET_BP)) begin
      bp_addr_d = cmd_arg;
      bp_en_d   = 1'b1;
    end else if (cmd_fire_s && (cmd_op == OP_CLR_BP)) begin
      bp_en_d = 1'b0;
    end else begin
      bp_en_d = bp_en_q;
    end

    // A halt caused by the retiring instruction wins over a command in the same cycle
    if (halt_req || bp_match_s || step_last_s) begin
      state_d    = ST_HALT;
      step_cnt_d = '0;
    end else begin
      step_cnt_d = step_cnt_d;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      step_cnt_q  <= '0;
      bp_addr_q   <= '0;
      bp_en_q     <= 1'b0;
      bp_hit_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      bp_addr_q   <= bp_addr_d;
      bp_en_q     <= bp_en_d;
      bp_hit_q    <= bp_hit_d;
      step_done_q <= step_done_d;
    end
  end

`ifdef DBG_INST_COUNT_EN
  logic [15:0] inst_count_q, inst_count_d;

  // Counter restarts whenever execution resumes from HALT
  always_comb begin
    inst_count_d = inst_count_q;
    if (resume_s) begin
      inst_count_d = 16'd0;
    end else if (counted_s) begin
      inst_count_d = inst_count_q + 16'd1;
    end else begin
      inst_count_d = inst_count_q;
    end
  end

  // Retired-instruction counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_count_q <= 16'd0;
    end else begin
      inst_count_q <= inst_count_d;
    end
  end

  assign inst_count = inst_count_q;
`else
  logic unused_s;
  assign unused_s   = resume_s;
  assign inst_count = 16'd0;
`endif

endmodule
